// File: rtl/soglia_load_ctrl.sv
// soglia_load_ctrl: serialises a W-bit signed threshold MSB first into the
// ser_par threshold register, then compares the register's parallel readback
// against the captured value and reports done / err.
module soglia_load_ctrl #(
  parameter int W   = 12,
  parameter int GAP = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_soglia,
  output logic         sp_enable,
  output logic         sp_din,
  input  logic [W-1:0] sp_soglia,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    cfg_q, cfg_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [3:0]      gapcnt_q, gapcnt_d;
  logic            err_q, err_d;

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cfg_d    = req_soglia;
          shreg_d  = req_soglia;
          bitcnt_d = BIT_LAST;
          gapcnt_d = 4'd0;
          err_d    = 1'b0;
          state_d  = S_SHIFT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SHIFT: begin
        // The bit on sp_din this cycle is consumed by ser_par at this edge.
        shreg_d = {shreg_q[W-2:0], 1'b0};
        if (bitcnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          bitcnt_d = bitcnt_q - BW'(1);
          if (GAP > 0) begin
            gapcnt_d = 4'd0;
            state_d  = S_GAP;
          end else begin
            state_d  = S_SHIFT;
          end
        end
      end
      S_GAP: begin
        if (gapcnt_q == GAP_LAST) begin
          gapcnt_d = 4'd0;
          state_d  = S_SHIFT;
        end else begin
          gapcnt_d = gapcnt_q + 4'd1;
          state_d  = S_GAP;
        end
      end
      S_CHECK: begin
        // Raw-bit equality: sign interpretation is irrelevant here.
        if (sp_soglia != cfg_q) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous reset abandons any load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      err_q    <= err_d;
    end
  end

  // Outputs are decoded purely from flops so no input reaches them combinationally.
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign sp_enable = (state_q == S_SHIFT);
  assign sp_din    = (state_q == S_SHIFT) & shreg_q[W-1];
  assign done      = (state_q == S_CHECK);
  assign err       = err_q;

endmodule

// File: tb/tb_soglia_load_ctrl.sv
// Testbench for soglia_load_ctrl: one instance with GAP=0 and one with GAP=2,
// each driving a behavioural ser_par model whose readback can be forced wrong.
module tb_soglia_load_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_ready, sp_enable, sp_din, busy, done, err;
  logic [11:0] req_soglia [2];
  logic [11:0] sp_reg     [2];
  logic [11:0] sp_rb      [2];
  logic [1:0]  bad;
  logic [11:0] badv       [2];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          inst;
    logic [11:0] v;
    bit          bd;
    logic [11:0] bv;
    bit          exp_err;
  } vec_t;

  vec_t tbl [6];

  soglia_load_ctrl #(.W(12), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_soglia(req_soglia[0]),
    .sp_enable(sp_enable[0]), .sp_din(sp_din[0]), .sp_soglia(sp_rb[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  soglia_load_ctrl #(.W(12), .GAP(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_soglia(req_soglia[1]),
    .sp_enable(sp_enable[1]), .sp_din(sp_din[1]), .sp_soglia(sp_rb[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ser_par: shift left, new bit in at LSB, when enabled.
  always @(posedge clk) begin
    if (sp_enable[0]) sp_reg[0] <= {sp_reg[0][10:0], sp_din[0]};
    if (sp_enable[1]) sp_reg[1] <= {sp_reg[1][10:0], sp_din[1]};
  end

  assign sp_rb[0] = bad[0] ? badv[0] : sp_reg[0];
  assign sp_rb[1] = bad[1] ? badv[1] : sp_reg[1];

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
  endtask

  task automatic check12(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %03h expected %03h at %0t", nm, act, exp, $time);
  endtask

  // One full load on instance i, checked cycle by cycle against the schedule
  // derived from W, GAP and the value.
  task automatic do_load(input int i, input logic [11:0] v, input bit bd,
                         input logic [11:0] bv, input bit exp_err);
    int g, len, k, t;
    logic en_e, din_e;
    g   = (i == 0) ? 0 : 2;
    len = 12 + 11 * g;
    bad[i]  = bd;
    badv[i] = bv;
    @(negedge clk);
    t = 0;
    while (!req_ready[i] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check1("ready_before", req_ready[i], 1'b1);
    req_soglia[i] = v;
    req_valid[i]  = 1'b1;
    @(negedge clk);
    req_valid[i]  = 1'b0;
    for (int n = 1; n <= len + 1; n++) begin
      en_e  = (n <= len) && (((n - 1) % (g + 1)) == 0);
      din_e = 1'b0;
      if (en_e) begin
        k     = (n - 1) / (g + 1);
        din_e = v[11 - k];
      end
      check1("sp_enable", sp_enable[i], en_e);
      check1("sp_din", sp_din[i], din_e);
      check1("done", done[i], n == len + 1);
      check1("busy", busy[i], 1'b1);
      check1("ready_busy", req_ready[i], 1'b0);
      check1("err_during", err[i], 1'b0);
      @(negedge clk);
    end
    check1("err_after", err[i], exp_err);
    check1("ready_after", req_ready[i], 1'b1);
    check1("busy_after", busy[i], 1'b0);
    check1("done_after", done[i], 1'b0);
    if (!bd) check12("readback", sp_reg[i], v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rv;
    int          ri, t;
    bit          rbd;

    rst        = 1'b1;
    req_valid  = 2'b00;
    bad        = 2'b00;
    sp_reg[0]  = 12'h000;
    sp_reg[1]  = 12'h000;
    badv[0]    = 12'h000;
    badv[1]    = 12'h000;
    req_soglia[0] = 12'h000;
    req_soglia[1] = 12'h000;

    tbl[0] = '{0, 12'h5A3, 1'b0, 12'h000, 1'b0};
    tbl[1] = '{0, 12'h5A3, 1'b1, 12'h5A2, 1'b1};
    tbl[2] = '{0, 12'h000, 1'b0, 12'h000, 1'b0};
    tbl[3] = '{1, 12'h800, 1'b0, 12'h000, 1'b0};
    tbl[4] = '{0, 12'hFFF, 1'b0, 12'h000, 1'b0};
    tbl[5] = '{1, 12'h7FF, 1'b1, 12'h7FE, 1'b1};

    // Reset values before any clock edge.
    #1;
    for (int i = 0; i < 2; i++) begin
      check1("rst_ready", req_ready[i], 1'b1);
      check1("rst_busy", busy[i], 1'b0);
      check1("rst_enable", sp_enable[i], 1'b0);
      check1("rst_din", sp_din[i], 1'b0);
      check1("rst_done", done[i], 1'b0);
      check1("rst_err", err[i], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int j = 0; j < 6; j++) begin
      do_load(tbl[j].inst, tbl[j].v, tbl[j].bd, tbl[j].bv, tbl[j].exp_err);
    end

    // Back-to-back with req_valid held high on the GAP=0 instance.
    bad[0] = 1'b0;
    @(negedge clk);
    req_soglia[0] = 12'h7FF;
    req_valid[0]  = 1'b1;
    @(negedge clk);
    req_soglia[0] = 12'h001;
    for (int n = 1; n <= 27; n++) begin
      check1("b2b_ready", req_ready[0], n == 14);
      check1("b2b_done", done[0], (n == 13) || (n == 27));
      check1("b2b_enable", sp_enable[0], (n <= 12) || ((n >= 15) && (n <= 26)));
      if (n == 14) check12("b2b_first", sp_reg[0], 12'h7FF);
      if (n == 15) req_valid[0] = 1'b0;
      @(negedge clk);
    end
    check1("b2b_ready_end", req_ready[0], 1'b1);
    check1("b2b_err", err[0], 1'b0);
    check12("b2b_final", sp_reg[0], 12'h001);

    // Reset after 5 bits of 0xFFF: immediate, no done afterwards.
    @(negedge clk);
    req_soglia[0] = 12'hFFF;
    req_valid[0]  = 1'b1;
    @(negedge clk);
    req_valid[0]  = 1'b0;
    for (int n = 0; n < 5; n++) @(negedge clk);
    check1("pre_rst_enable", sp_enable[0], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check1("arst_enable", sp_enable[0], 1'b0);
    check1("arst_din", sp_din[0], 1'b0);
    check1("arst_done", done[0], 1'b0);
    check1("arst_err", err[0], 1'b0);
    check1("arst_ready", req_ready[0], 1'b1);
    check1("arst_busy", busy[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    for (int n = 0; n < 15; n++) begin
      if (done[0] || busy[0]) t++;
      @(negedge clk);
    end
    check1("post_rst_quiet", t == 0, 1'b1);
    do_load(0, 12'h123, 1'b0, 12'h000, 1'b0);

    // Randomized loads against the schedule model.
    for (int j = 0; j < 16; j++) begin
      ri  = int'($urandom_range(0, 1));
      rv  = 12'($urandom_range(0, 4095));
      rbd = ($urandom_range(0, 3) == 0);
      do_load(ri, rv, rbd, rv ^ (12'd1 << $urandom_range(0, 11)), rbd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/soglia_load_ctrl.md
# soglia_load_ctrl

Sequencer that loads a 12-bit signed spike-detection threshold into the serial-to-parallel threshold register (`ser_par`). It serialises the value MSB first and drives that register's `enable`/`din` pins. After the last bit it reads the register's parallel output back and reports done or mismatch. It sits between the configuration front end (valid/ready request) and `ser_par` in the detector backend.

## Interface
- `W`, 12, threshold width; must equal the `ser_par` width.
- `GAP`, 0, idle cycles inserted between consecutive bits (0 = one bit per cycle); range 0..15.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_valid`  in  1  request to load `req_soglia`.
- `req_ready`  out  1  controller can accept a request.
- `req_soglia`  in  W  signed threshold to load; sampled on accept.
- `sp_enable`  out  1  to `ser_par.enable`; shift strobe.
- `sp_din`  out  1  to `ser_par.din`; current serial bit.
- `sp_soglia`  in  W  readback from `ser_par.soglia`.
- `busy`  out  1  load in progress (states other than IDLE).
- `done`  out  1  one-cycle pulse: load complete, readback compared.
- `err`  out  1  sticky: last readback mismatched; cleared on next accept.

## Operation
- The FSM uses the states IDLE, SHIFT, GAP and CHECK.
- The block holds two W-bit registers:
  - `cfg`: captured value, kept for the compare.
  - `shreg`: shifted left one bit per bit sent.
- A bit counter runs 0..W-1. A gap counter runs 0..GAP-1.
- IDLE:
  - `req_ready`=1.
  - On `req_valid & req_ready`: load `cfg` and `shreg` from `req_soglia`, set bitcnt=W-1, clear `err`, go to SHIFT.
- SHIFT:
  - `sp_enable`=1, `sp_din`=`shreg[W-1]`.
  - At the clock edge: shift `shreg` left by one.
  - If bitcnt==0, go to CHECK.
  - Otherwise decrement bitcnt; go to GAP if GAP>0, else stay in SHIFT.
- GAP:
  - `sp_enable`=0, `sp_din`=0.
  - Count GAP cycles, then return to SHIFT.
- CHECK:
  - `done`=1 for exactly one cycle.
  - If `sp_soglia` != `cfg`, set `err`=1 at the clock edge.
  - Go to IDLE.
- Outputs outside SHIFT: `sp_enable`=0, `sp_din`=0.
- `sp_enable`, `sp_din` and `done` are decoded only from flops (state, `shreg`). No combinational path runs from any input to them.
- `req_ready` = (state==IDLE). Requests arriving while busy are held off and are never dropped or queued.
- The compare is a full W-bit equality on raw bits, so sign does not matter.
- `ser_par` has its own synchronous reset. Clearing it is the system's responsibility. The controller always writes all W bits, so stale contents are fully overwritten.

## Timing
- Reset values (async, immediate): state=IDLE, `req_ready`=1, `busy`=0, `sp_enable`=0, `sp_din`=0, `done`=0, `err`=0, all internal registers 0.
- Accept at edge E0. SHIFT occupies the cycles after E0. `sp_enable`=1 for W cycles, with GAP idle cycles between bits. The shift phase totals W+(W-1)·GAP cycles.
- `ser_par` samples the last bit at the edge that ends the final SHIFT cycle. `sp_soglia` is therefore valid in the CHECK cycle, which immediately follows that SHIFT cycle.
- Accept-to-done latency:
  - `done` is high in cycle W+(W-1)·GAP+1 after E0.
  - With GAP=0, `done` is high in cycle 13.
- `req_ready` returns to 1 in the cycle after `done`. The next accept can happen at that cycle's edge.
- Back-to-back loads with `req_valid` held high: one load per W+(W-1)·GAP+2 cycles, i.e. 14 cycles for GAP=0.
- `err`:
  - Updates at the edge ending CHECK and is visible from the cycle after `done`.
  - Holds its value until the next accept.
- Reset during SHIFT or GAP:
  - All outputs return immediately to their reset values.
  - The partial `ser_par` content is undefined. The load is abandoned: no `done`, no `err`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `sp_enable`=0, `done`=0, `err`=0, `req_ready`=1, `busy`=0 without waiting for a clock edge.
- GAP=0, load 0x5A3 with a real `ser_par` attached:
  - `sp_enable` high for cycles 1–12.
  - `sp_din` = 0,1,0,1,1,0,1,0,0,0,1,1.
  - `done` in cycle 13, `err`=0, `ser_par.soglia`=0x5A3.
- Mismatch: behavioural readback stuck at 0x5A2 while loading 0x5A3 → `done` in cycle 13, `err`=1 from cycle 14. A following load of 0x000 with correct readback clears `err` to 0 at accept.
- GAP=2, load 0x800 (−2048):
  - `sp_enable` pattern repeats 1,0,0; 12 pulses over 34 cycles.
  - `sp_din`=1 only on the first pulse.
  - `done` in cycle 35; readback 0x800, `err`=0.
- Back-to-back with `req_valid` held high, GAP=0: 0x7FF then 0x001 → accepts 14 cycles apart, `req_ready`=0 while busy, both `done` pulses present, final `soglia`=0x001.
- Reset after 5 bits of 0xFFF → outputs reset immediately, no `done`. After release, a load of 0x123 completes normally with `err`=0.
